// File: rtl/jk_pkg.sv
// Shared types for the JK register bank: per-bit interpretation modes,
// the width limit and a popcount helper used by the optional flip counter.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK = 2'b00,
    JK_MODE_D  = 2'b01,
    JK_MODE_T  = 2'b10,
    JK_MODE_SR = 2'b11
  } jk_mode_e;

  localparam int JK_MAX_WIDTH = 64;

  function automatic logic [6:0] jk_popcnt(input logic [JK_MAX_WIDTH-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < JK_MAX_WIDTH; i++) n = n + 7'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Next-state logic for one storage bit under the selected mode, plus
// detection of the illegal SR input combination (S=R=1).
module jk_bit_cell
  import jk_pkg::*;
(
  input  jk_mode_e i_mode,
  input  logic     i_q,
  input  logic     i_j,
  input  logic     i_k,
  output logic     o_q_nxt,
  output logic     o_illegal
);

  always_comb begin
    o_q_nxt   = i_q;
    o_illegal = 1'b0;
    unique case (i_mode)
      JK_MODE_JK: begin
        case ({i_j, i_k})
          2'b01:   o_q_nxt = 1'b0;
          2'b10:   o_q_nxt = 1'b1;
          2'b11:   o_q_nxt = ~i_q;
          default: o_q_nxt = i_q;
        endcase
      end
      JK_MODE_D: o_q_nxt = i_j;
      JK_MODE_T: o_q_nxt = i_j ? ~i_q : i_q;
      JK_MODE_SR: begin
        case ({i_j, i_k})
          2'b01:   o_q_nxt = 1'b0;
          2'b10:   o_q_nxt = 1'b1;
          2'b11:   o_illegal = 1'b1;  // bit holds; sticky error raised in the bank
          default: o_q_nxt = i_q;
        endcase
      end
      default: o_q_nxt = i_q;
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH mode-selectable JK-style bits with change pulses and a sticky
// SR-illegal flag. Define JK_FLIP_CNT_EN to add the saturating flip counter.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
`ifdef JK_FLIP_CNT_EN
  parameter int               CNT_W     = 16,
`endif
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] changed,
  output logic             sr_err
`ifdef JK_FLIP_CNT_EN
  ,
  output logic [CNT_W-1:0] flip_cnt
`endif
);

  jk_mode_e         w_mode;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_ill;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_err;

  assign w_mode = jk_mode_e'(mode);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_bit_cell u_cell (
      .i_mode    (w_mode),
      .i_q       (r_q[g]),
      .i_j       (j[g]),
      .i_k       (k[g]),
      .o_q_nxt   (w_q_nxt[g]),
      .o_illegal (w_ill[g])
    );
  end

  assign w_chg = en ? (w_q_nxt ^ r_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RESET_VAL;
      r_chg <= '0;
      r_err <= 1'b0;
    end else begin
      r_chg <= w_chg;
      if (en) r_q <= w_q_nxt;
      if (en && |w_ill) r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  // Qn is derived, never stored, so it cannot drift from Q.
  assign Q       = r_q;
  assign Qn      = ~r_q;
  assign changed = r_chg;
  assign sr_err  = r_err;

`ifdef JK_FLIP_CNT_EN
  localparam logic [CNT_W+7:0] CNT_MAX = {8'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_pop;
  logic [CNT_W+7:0] w_sum;

  assign w_pop = jk_popcnt(JK_MAX_WIDTH'(w_chg));
  assign w_sum = {8'b0, r_cnt} + (CNT_W+8)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst)     r_cnt <= '0;
    else if (en) r_cnt <= (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  assign flip_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a behavioural model predicts each cycle,
// predictions are queued on drive and popped after the clock edge.
module tb_jk_reg_bank;
  import jk_pkg::*;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam int         CW = 4;
  localparam int         CMAX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] Q, Qn, changed;
  logic         sr_err;
`ifdef JK_FLIP_CNT_EN
  logic [CW-1:0] flip_cnt;
`endif

  jk_reg_bank #(
    .WIDTH     (W),
`ifdef JK_FLIP_CNT_EN
    .CNT_W     (CW),
`endif
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .j        (j),
    .k        (k),
    .clr_err  (clr_err),
    .Q        (Q),
    .Qn       (Qn),
    .changed  (changed),
    .sr_err   (sr_err)
`ifdef JK_FLIP_CNT_EN
    ,
    .flip_cnt (flip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] qn;
    logic [7:0] chg;
    logic       err;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] m_q = '0;
  logic       m_err = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic c);
    exp_t       x;
    logic [7:0] nq;
    logic       ill;
    rst = r; en = e; mode = m; j = jj; k = kk; clr_err = c;
    nq  = m_q;
    ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'b00: if (jj[i] && kk[i]) nq[i] = ~m_q[i]; else if (jj[i]) nq[i] = 1'b1;
               else if (kk[i]) nq[i] = 1'b0;
        2'b01: nq[i] = jj[i];
        2'b10: if (jj[i]) nq[i] = ~m_q[i];
        default: if (jj[i] && kk[i]) ill = 1'b1; else if (jj[i]) nq[i] = 1'b1;
                 else if (kk[i]) nq[i] = 1'b0;
      endcase
    end
    if (r) begin
      x.chg = '0; m_q = RV; m_err = 1'b0; m_cnt = 0;
    end else if (e) begin
      x.chg = nq ^ m_q;
      m_q   = nq;
      if (ill) m_err = 1'b1; else if (c) m_err = 1'b0;
      m_cnt = m_cnt + $countones(x.chg);
      if (m_cnt > CMAX) m_cnt = CMAX;
    end else begin
      x.chg = '0;
      if (c) m_err = 1'b0;
    end
    x.q = m_q; x.qn = ~m_q; x.err = m_err; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q", 64'(Q), 64'(x.q));
    chk("qn", 64'(Qn), 64'(x.qn));
    chk("changed", 64'(changed), 64'(x.chg));
    chk("sr_err", 64'(sr_err), 64'(x.err));
`ifdef JK_FLIP_CNT_EN
    chk("flip_cnt", 64'(flip_cnt), 64'(x.cnt));
`endif
  endtask

  initial begin
    // reset, two cycles
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    chk("rst_q", 64'(Q), 64'hA5);
    chk("rst_qn", 64'(Qn), 64'h5A);
    chk("rst_chg", 64'(changed), 64'h0);
    // JK set/clear then toggle-all
    step(0, 1, 2'b01, 8'h00, 8'h00, 0);
    step(0, 1, 2'b00, 8'hF0, 8'h0F, 0);
    chk("jk_setclr", 64'(Q), 64'hF0);
    chk("jk_setclr_chg", 64'(changed), 64'hF0);
    step(0, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("jk_tog", 64'(Q), 64'h0F);
    chk("jk_tog_chg", 64'(changed), 64'hFF);
    // D, hold, T
    step(0, 1, 2'b01, 8'h3C, 8'hFF, 0);
    chk("d_load", 64'(Q), 64'h3C);
    step(0, 0, 2'b10, 8'hFF, 8'hFF, 0);
    chk("en0_hold", 64'(Q), 64'h3C);
    chk("en0_chg", 64'(changed), 64'h0);
    step(0, 1, 2'b10, 8'h01, 8'hAA, 0);
    chk("t_tog", 64'(Q), 64'h3D);
    // SR illegal, set-beats-clear, then clear
    step(0, 1, 2'b01, 8'h00, 8'h00, 0);
    step(0, 1, 2'b11, 8'h81, 8'h81, 0);
    chk("sr_ill_q", 64'(Q), 64'h00);
    chk("sr_ill_err", 64'(sr_err), 64'h1);
    step(0, 1, 2'b11, 8'h01, 8'h01, 1);
    chk("sr_set_prio", 64'(sr_err), 64'h1);
    step(0, 1, 2'b11, 8'h00, 8'h00, 1);
    chk("sr_clr", 64'(sr_err), 64'h0);
    // SR set/clear/hold mix
    step(0, 1, 2'b11, 8'hF0, 8'h0C, 0);
    chk("sr_mix", 64'(Q), 64'hF0);
    // saturation: toggle all from reset
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    step(0, 1, 2'b00, 8'hFF, 8'hFF, 0);
    step(0, 1, 2'b00, 8'hFF, 8'hFF, 0);
`ifdef JK_FLIP_CNT_EN
    chk("cnt_sat", 64'(flip_cnt), 64'd15);
`endif
    step(0, 1, 2'b00, 8'hFF, 8'hFF, 0);
`ifdef JK_FLIP_CNT_EN
    chk("cnt_sat_hold", 64'(flip_cnt), 64'd15);
`endif
    // reset wins over same-cycle toggle
    step(1, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("rst_prio_q", 64'(Q), 64'hA5);
    chk("rst_prio_chg", 64'(changed), 64'h0);
`ifdef JK_FLIP_CNT_EN
    chk("rst_prio_cnt", 64'(flip_cnt), 64'd0);
`endif
    // random traffic
    for (int n = 0; n < 80; n++)
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
           8'($urandom), 8'($urandom), ($urandom_range(3) == 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK-style storage bits with a run-time selectable interpretation (JK, D, T, SR) of the per-bit `j`/`k` inputs. Each bit also reports a per-bit change pulse, and a sticky flag records illegal SR input. An optional saturating counter totals all bit flips. The bank replaces single-bit JK flip-flops wherever control or status registers need per-bit set/clear/toggle semantics.

## Interface
- WIDTH, 8, number of storage bits (1..64)
- CNT_W, 16, width of flip counter (compiled only with macro)
- RESET_VAL, '0, WIDTH-bit value loaded into Q on reset
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  reset, synchronous, active-high
- en  in  1  update enable; low = hold everything
- mode  in  2  00 JK, 01 D, 10 T, 11 SR
- j  in  WIDTH  per-bit J / D / T / S input
- k  in  WIDTH  per-bit K / – / – / R input
- clr_err  in  1  clears sr_err
- Q  out  WIDTH  stored state
- Qn  out  WIDTH  bitwise complement of Q
- changed  out  WIDTH  per-bit flag: bit changed at last edge
- sr_err  out  1  sticky: SR mode saw j=k=1 on some bit with en high
- flip_cnt  out  CNT_W  saturating total of bit flips (macro only)

## Operation
- Per-bit next state when en=1 (j,k per bit):
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - D: Q=j; k ignored.
  - T: j=1 toggles, j=0 holds; k ignored.
  - SR: 10 set, 01 clear, 00 hold, 11 illegal → hold that bit, set sr_err.
- en=0: Q holds, changed=0, sr_err not set (clr_err still honoured), flip_cnt holds.
- changed[i] = Q_next[i] XOR Q[i], registered with Q.
- sr_err: set has priority over clr_err in the same cycle; otherwise clr_err=1 clears.
- mode may change on any cycle; the new mode applies at that same edge; Q is not disturbed by the change itself.
- Reset (priority over all inputs): Q=RESET_VAL, Qn=~RESET_VAL, changed=0, sr_err=0, flip_cnt=0. Reset asserted mid-run discards that cycle's update.

## Timing
- All outputs registered; inputs sampled at rising clk; results visible one cycle later.
- Q, Qn, changed, sr_err, flip_cnt update on the same edge; no combinational input-to-output path.
- Latency: 1 cycle from input to Q. Back-to-back updates every cycle supported.
- Qn is never a separately stored state; always exactly ~Q.

## Configuration
- JK_FLIP_CNT_EN defined: flip_cnt present; each enabled edge adds popcount(changed_next); result saturates at 2^CNT_W−1 and holds there until reset.
- Undefined: flip_cnt port and counter logic absent; all other behaviour identical.

## Structure
- Package jk_pkg: enum jk_mode_e (JK_MODE_JK=2'b00, JK_MODE_D=2'b01, JK_MODE_T=2'b10, JK_MODE_SR=2'b11); constant for max WIDTH.
- Sub-module jk_bit_cell: combinational next-state and illegal-SR detect for one bit, instantiated WIDTH times via generate; storage, sticky flag and counter live in jk_reg_bank.

## Test plan
- Reset with RESET_VAL=8'hA5, rst=1 for 2 cycles → Q=8'hA5, Qn=8'h5A, changed=0, sr_err=0, flip_cnt=0.
- JK mode, Q=8'h00, j=8'hF0 k=8'h0F, then j=k=8'hFF → Q=8'hF0 (changed=8'hF0), then Q=8'h0F (changed=8'hFF, flip_cnt=12).
- D mode j=8'h3C, then T mode j=8'h01, en=0 one cycle between → Q=8'h3C, holds with changed=0, then Q=8'h3D.
- SR mode j=k=8'h81 with Q=8'h00 → Q unchanged, sr_err=1; next cycle clr_err=1 with j=k=8'h01 → sr_err stays 1; clr_err=1 with j=k=0 → sr_err=0.
- Saturation, CNT_W=4: JK toggle all 8 bits twice → flip_cnt=15 and stays 15 on further toggles.
- rst asserted in same cycle as JK toggle → Q=RESET_VAL, toggle discarded, flip_cnt=0.
